uart_fifo_periph: RTL

UART_FIFO_PERIPH -- requirements
Module: uart_fifo_periph

---
 rtl/uart_fifo_periph.sv | 357 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_periph.sv
// uart_fifo_periph: register-mapped 8N1 UART with a TX FIFO and an RX FIFO.
//
// Optional feature: define UART_IRQ_EN to add the registered irq output and a
// writable IRQEN register. Without it, irq does not exist and IRQEN reads 0x00.
//
// Ports:
//   clk       in   system clock, all logic on the rising edge
//   rst       in   synchronous active-high reset
//   uart_cs   in   access strobe, one register access per high cycle
//   R_W_n     in   1 = read, 0 = write
//   reg_addr  in   register select (0 TXDATA, 1 STATUS, 2 RXDATA, 3 DIV_LO,
//                  4 DIV_HI, 5 RXLEVEL, 6 IRQEN, 7 reads 0x00)
//   data_i    in   write data
//   data_o    out  read data, combinational from reg_addr
//   uart_rx   in   asynchronous serial input
//   uart_tx   out  serial output
//   irq       out  interrupt request (only with UART_IRQ_EN)
module uart_fifo_periph #(
  parameter int CLK_FRE    = 27,
  parameter int UART_FRE   = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_cs,
  input  logic       R_W_n,
  input  logic [2:0] reg_addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  input  logic       uart_rx,
  output logic       uart_tx
`ifdef UART_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [15:0]   DIV_RST = 16'(CLK_FRE * 1000000 / UART_FRE);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Bit periods shorter than 4 clocks break the half-bit recheck on RX.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < 16'd4) ? 16'd4 : d;
  endfunction

  // RXLEVEL is 8 bits wide; a 256-deep FIFO that is full reports 255.
  function automatic logic [7:0] sat_level(input logic [CW-1:0] c);
    if (int'(c) > 255) return 8'hFF;
    return 8'(c);
  endfunction

  // Bus decode
  logic wr_acc, rd_acc, status_wr;
  assign wr_acc    = uart_cs & ~R_W_n;
  assign rd_acc    = uart_cs &  R_W_n;
  assign status_wr = wr_acc && (reg_addr == 3'd1);

  logic [7:0]  div_lo_q, div_hi_q, txdata_q;
  logic [15:0] div_q;
  assign div_q = {div_hi_q, div_lo_q};

  logic ovr_q, fe_q, txovf_q;

  // TX FIFO
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_rd_q;
  logic [CW-1:0] txf_cnt_q;
  logic          tx_empty, tx_full, tx_push, tx_pop, tx_ovf_set;

  assign tx_empty   = (txf_cnt_q == '0);
  assign tx_full    = (txf_cnt_q == DEPTH_C);
  assign tx_push    = wr_acc && (reg_addr == 3'd0) && !tx_full;
  assign tx_ovf_set = wr_acc && (reg_addr == 3'd0) &&  tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      txf_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   txf_cnt_q <= txf_cnt_q + 1'b1;
        2'b01:   txf_cnt_q <= txf_cnt_q - 1'b1;
        default: txf_cnt_q <= txf_cnt_q;
      endcase
    end
  end

  // TX FSM: uart_tx is a register, so the pop cycle also drives the start bit.
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_clk_q, tx_clk_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_line_q, tx_line_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_clk_d   = tx_clk_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_div_d   = tx_div_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_clk_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem_q[tx_rd_q];
          tx_div_d   = clamp_div(div_q);
          tx_line_d  = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_clk_q == tx_div_q - 16'd1) begin
          tx_clk_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_clk_q == tx_div_q - 16'd1) begin
          tx_clk_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_clk_q == tx_div_q - 16'd1) begin
          tx_clk_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem_q[tx_rd_q];
            tx_div_d   = clamp_div(div_q);
            tx_line_d  = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_clk_q   <= '0;
      tx_bit_q   <= '0;
      tx_div_q   <= DIV_RST;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_clk_q   <= tx_clk_d;
      tx_bit_q   <= tx_bit_d;
      tx_div_q   <= tx_div_d;
      tx_line_q  <= tx_line_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
  end

  assign uart_tx = tx_line_q;

  // RX synchroniser; rx_prev_q holds the previous synchronised level for edge detect.
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX FIFO
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_q, rx_rd_q;
  logic [CW-1:0] rxf_cnt_q;
  logic          rx_empty, rx_full, rx_good, rx_fe_set, rx_push, rx_pop, rx_ovr_set;

  assign rx_empty   = (rxf_cnt_q == '0);
  assign rx_full    = (rxf_cnt_q == DEPTH_C);
  assign rx_push    = rx_good & ~rx_full;
  assign rx_ovr_set = rx_good &  rx_full;
  assign rx_pop     = rd_acc && (reg_addr == 3'd2) && !rx_empty;

  // RX FSM
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_clk_q, rx_clk_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_clk_d   = rx_clk_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_div_d   = rx_div_q;
    rx_good    = 1'b0;
    rx_fe_set  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_clk_d = '0;
        if (rx_prev_q && !rx_s2_q) begin
          rx_div_d   = clamp_div(div_q);
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Mid start bit: a line already back high was a glitch.
        if (rx_clk_q == (rx_div_q >> 1) - 16'd1) begin
          rx_clk_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_clk_q == rx_div_q - 16'd1) begin
          rx_clk_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_clk_q == rx_div_q - 16'd1) begin
          rx_clk_d   = '0;
          rx_good    = rx_s2_q;
          rx_fe_set  = ~rx_s2_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_clk_q   <= '0;
      rx_bit_q   <= '0;
      rx_div_q   <= DIV_RST;
    end else begin
      rx_state_q <= rx_state_d;
      rx_clk_q   <= rx_clk_d;
      rx_bit_q   <= rx_bit_d;
      rx_div_q   <= rx_div_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    if (rx_push) rx_mem_q[rx_wr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rxf_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rxf_cnt_q <= rxf_cnt_q + 1'b1;
        2'b01:   rxf_cnt_q <= rxf_cnt_q - 1'b1;
        default: rxf_cnt_q <= rxf_cnt_q;
      endcase
    end
  end

  // Configuration registers and sticky status; a new event wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_lo_q <= DIV_RST[7:0];
      div_hi_q <= DIV_RST[15:8];
      txdata_q <= 8'h00;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
      txovf_q  <= 1'b0;
    end else begin
      if (wr_acc && reg_addr == 3'd3) div_lo_q <= data_i;
      if (wr_acc && reg_addr == 3'd4) div_hi_q <= data_i;
      if (tx_push) txdata_q <= data_i;
      ovr_q   <= rx_ovr_set | (ovr_q   & ~(status_wr & data_i[3]));
      fe_q    <= rx_fe_set  | (fe_q    & ~(status_wr & data_i[4]));
      txovf_q <= tx_ovf_set | (txovf_q & ~(status_wr & data_i[5]));
    end
  end

  logic [7:0] irqen_rd;
`ifdef UART_IRQ_EN
  logic [7:0] irqen_q;
  logic       irq_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      irqen_q <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      if (wr_acc && reg_addr == 3'd6) irqen_q <= data_i;
      irq_q <= (irqen_q[0] & ~rx_empty) | (irqen_q[1] & tx_empty) |
               (irqen_q[2] & (ovr_q | fe_q | txovf_q));
    end
  end
  assign irqen_rd = irqen_q;
  assign irq      = irq_q;
`else
  assign irqen_rd = 8'h00;
`endif

  logic [7:0] status;
  assign status = {2'b00, txovf_q, fe_q, ovr_q,
                   (tx_empty && tx_state_q == TX_IDLE), ~rx_empty, ~tx_full};

  always_comb begin
    data_o = 8'h00;
    case (reg_addr)
      3'd0:    data_o = txdata_q;
      3'd1:    data_o = status;
      3'd2:    data_o = rx_mem_q[rx_rd_q];
      3'd3:    data_o = div_lo_q;
      3'd4:    data_o = div_hi_q;
      3'd5:    data_o = sat_level(rxf_cnt_q);
      3'd6:    data_o = irqen_rd;
      default: data_o = 8'h00;
    endcase
  end

endmodule
